ulx3s_board_io: RTL and testbench
=================================

# ulx3s_board_io

Board-level I/O controller for the ULX3S bootloader top: synchronises and debounces the raw push-buttons, generates the bootloader reset as a power-on pulse and from a long press, and drives the LED bank through per-LED display modes. Replaces the direct button-to-reset/LED wiring in the board top with parametrised, glitch-free sequential logic. Sits between the board pins and `tinyfpga_bootloader`.

## Interface
- `N_BTN`, 7, number of buttons
- `N_LED`, 8, number of LEDs
- `DB_CYCLES`, 480000, stable cycles required to accept a button change (10 ms at 48 MHz)
- `LONG_CYCLES`, 48000000, hold cycles on `RST_BTN` that trigger reset (1 s)
- `PULSE_CYCLES`, 1024, length of `sys_reset` pulse
- `RST_BTN`, 1, index of reset button
- `BLINK_DIV`, 12000000, cycles per blink half-period (2 Hz)
- `clk_48mhz`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `btn_raw`  in  N_BTN  asynchronous button pins, active-high
- `btn_db`  out  N_BTN  debounced level
- `btn_rise`  out  N_BTN  one-cycle pulse on accepted press
- `btn_fall`  out  N_BTN  one-cycle pulse on accepted release
- `short_press`  out  1  one-cycle pulse: `RST_BTN` released before `LONG_CYCLES`
- `sys_reset`  out  1  active-high reset to bootloader
- `led_src`  in  N_LED  per-LED status input
- `led_mode`  in  2*N_LED  mode per LED, bits [2i+1:2i]
- `led`  out  N_LED  LED pins, active-high

## Operation
- Per button: 2-FF synchroniser, then counter. If synced != `btn_db[i]`, increment; at `DB_CYCLES-1` update `btn_db[i]`, clear counter, pulse `btn_rise`/`btn_fall` same cycle as update. If synced == `btn_db[i]`, counter clears (any glitch restarts the window).
- Reset FSM states: PULSE, IDLE, HOLD, WAIT_REL.
  - PULSE: `sys_reset`=1, count `PULSE_CYCLES`, then -> WAIT_REL.
  - WAIT_REL: `sys_reset`=0; -> IDLE when `btn_db[RST_BTN]`=0 (no retrigger from one held press).
  - IDLE: on `btn_rise[RST_BTN]` -> HOLD, hold counter cleared.
  - HOLD: counts while pressed; at `LONG_CYCLES-1` -> PULSE; on `btn_fall[RST_BTN]` -> IDLE with `short_press`=1 for one cycle.
- LED modes (package constants): 00 OFF → 0; 01 DIRECT → `led_src[i]`; 10 BLINK → `led_src[i]` & blink phase; 11 DIM → `led_src[i]` & (pwm_cnt==0), 3-bit free-running pwm_cnt (12.5 % duty).
- Blink phase: shared counter toggles phase every `BLINK_DIV` cycles; all LEDs share phase. `led` registered.
- Counter widths `$clog2(param)`; counters saturate never wrap in use (they clear at terminal count).

## Timing
- Reset values (while `reset_n`=0): `btn_db`, `btn_rise`, `btn_fall`, `short_press`, `led` = 0; sync FFs, counters, blink phase, pwm_cnt = 0; FSM = PULSE, `sys_reset`=1.
- After `reset_n` rises: `sys_reset` high exactly `PULSE_CYCLES` cycles counted from first cycle out of reset (power-on pulse).
- Button latency: raw edge to `btn_db` change = 2 + `DB_CYCLES` cycles for clean edge.
- Long press: `sys_reset` rises `LONG_CYCLES` cycles after `btn_rise[RST_BTN]`.
- `short_press` asserted cycle after `btn_fall` seen in HOLD.
- `led` follows `led_src`/`led_mode` with 1-cycle latency.
- `reset_n` low mid-pulse or mid-hold: abandons state, restarts full power-on pulse.
- Press and release on the same debounced cycle impossible; `btn_rise`/`btn_fall` mutually exclusive per button.

## Structure
- `board_io_pkg`: LED mode constants (OFF, DIRECT, BLINK, DIM), reset FSM state enum.
- Sub-module `btn_debounce` (sync + counter + edge pulses, param `DB_CYCLES`), generated N_BTN times. FSM and LED mux in top.

## Test plan
Simulate with `DB_CYCLES`=4, `LONG_CYCLES`=20, `PULSE_CYCLES`=8, `BLINK_DIV`=6.
- Release `reset_n` → `sys_reset`=1 for exactly 8 cycles, then 0; all other outputs 0.
- `btn_raw[0]` 1 for 3 cycles then 0 → `btn_db[0]` stays 0, no rise pulse; 1 held → `btn_db[0]`=1 at cycle 6, one-cycle `btn_rise[0]`.
- Hold `btn_raw[1]` 40 cycles → `sys_reset` 8-cycle pulse 20 cycles after `btn_rise[1]`; no second pulse until released and re-pressed.
- Press `btn_raw[1]` 10 cycles, release → `short_press` single pulse, `sys_reset` stays 0.
- `led_src`=8'hFF, `led_mode`=16'b11_10_01_00 repeated → led[0]=0, led[1]=1, led[2] toggles every 6 cycles, led[3] high 1 of 8 cycles.
- Assert `reset_n`=0 during HOLD at count 15 → on release, fresh 8-cycle `sys_reset`, HOLD count discarded.

Source files
------------

// File: rtl/board_io_pkg.sv
// board_io_pkg
// Shared definitions for the ULX3S board I/O controller: the per-LED display
// mode encodings, the reset FSM state type, and a helper that sizes counters
// so a parameter of 1 still yields a legal one-bit register.
package board_io_pkg;

  // Two-bit display mode per LED, packed as led_mode[2i+1:2i]
  localparam logic [1:0] LED_OFF    = 2'b00;
  localparam logic [1:0] LED_DIRECT = 2'b01;
  localparam logic [1:0] LED_BLINK  = 2'b10;
  localparam logic [1:0] LED_DIM    = 2'b11;

  // Width of the free-running PWM counter used by DIM (1 of 8 cycles on)
  localparam int PWM_BITS = 3;

  typedef enum logic [1:0] {
    ST_PULSE    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } rst_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One push-button path: 2-FF synchroniser followed by a stability counter.
// A change of the synchronised level is accepted only after it has been
// stable for DB_CYCLES consecutive cycles; any return to the accepted level
// restarts the window.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   raw      asynchronous button pin, active-high
//   db       debounced level
//   rise     one-cycle pulse in the cycle db goes high
//   fall     one-cycle pulse in the cycle db goes low
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES = 480000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Edge pulses are produced in the same cycle db is updated, so they are
  // mutually exclusive and never repeat while the level is held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != db) begin
        if (cnt == CNT_LAST) begin
          db   <= sync[1];
          cnt  <= '0;
          rise <= sync[1];
          fall <= ~sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ulx3s_board_io.sv
// ulx3s_board_io
// Board-level I/O controller sitting between the ULX3S pins and the
// bootloader. Debounces the buttons, generates the bootloader reset (a
// power-on pulse, and again after a long press of RST_BTN), and drives the
// LED bank through per-LED display modes.
// Ports:
//   clk_48mhz    system clock
//   reset_n      synchronous active-low reset
//   btn_raw      asynchronous button pins, active-high
//   btn_db       debounced button levels
//   btn_rise     one-cycle pulses on accepted presses
//   btn_fall     one-cycle pulses on accepted releases
//   short_press  one-cycle pulse when RST_BTN is released before a long press
//   sys_reset    active-high reset to the bootloader
//   led_src      per-LED status inputs
//   led_mode     two-bit display mode per LED
//   led          registered LED pins, active-high
module ulx3s_board_io
  import board_io_pkg::*;
#(
  parameter int N_BTN        = 7,
  parameter int N_LED        = 8,
  parameter int DB_CYCLES    = 480000,
  parameter int LONG_CYCLES  = 48000000,
  parameter int PULSE_CYCLES = 1024,
  parameter int RST_BTN      = 1,
  parameter int BLINK_DIV    = 12000000
) (
  input  logic               clk_48mhz,
  input  logic               reset_n,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_db,
  output logic [N_BTN-1:0]   btn_rise,
  output logic [N_BTN-1:0]   btn_fall,
  output logic               short_press,
  output logic               sys_reset,
  input  logic [N_LED-1:0]   led_src,
  input  logic [2*N_LED-1:0] led_mode,
  output logic [N_LED-1:0]   led
);

  localparam int PULSE_W = cnt_width(PULSE_CYCLES);
  localparam int HOLD_W  = cnt_width(LONG_CYCLES);
  localparam int BLINK_W = cnt_width(BLINK_DIV);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  // The cycle in which IDLE reacts to btn_rise is the first held cycle, so
  // HOLD terminates one count early; sys_reset then rises exactly
  // LONG_CYCLES cycles after btn_rise.
  localparam logic [HOLD_W-1:0]  HOLD_LAST  =
    HOLD_W'((LONG_CYCLES > 2) ? (LONG_CYCLES - 2) : 0);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk    (clk_48mhz),
        .reset_n(reset_n),
        .raw    (btn_raw[g]),
        .db     (btn_db[g]),
        .rise   (btn_rise[g]),
        .fall   (btn_fall[g])
      );
    end
  endgenerate

  rst_state_t         state;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [HOLD_W-1:0]  hold_cnt;

  // Reset FSM. WAIT_REL after every pulse stops a single held press from
  // retriggering; a release in HOLD wins over the terminal count.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state       <= ST_PULSE;
      pulse_cnt   <= '0;
      hold_cnt    <= '0;
      sys_reset   <= 1'b1;
      short_press <= 1'b0;
    end else begin
      short_press <= 1'b0;
      case (state)
        ST_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state     <= ST_WAIT_REL;
            pulse_cnt <= '0;
            sys_reset <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!btn_db[RST_BTN]) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (btn_rise[RST_BTN]) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (btn_fall[RST_BTN]) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= ST_PULSE;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
            sys_reset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_PULSE;
          pulse_cnt <= '0;
          hold_cnt  <= '0;
          sys_reset <= 1'b1;
        end
      endcase
    end
  end

  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Shared blink phase and dim PWM timebase, followed by the registered
  // per-LED mode mux; all LEDs use the same phase so they blink in step.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      led         <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      for (int i = 0; i < N_LED; i++) begin
        case (led_mode[2*i +: 2])
          LED_OFF:    led[i] <= 1'b0;
          LED_DIRECT: led[i] <= led_src[i];
          LED_BLINK:  led[i] <= led_src[i] & blink_phase;
          LED_DIM:    led[i] <= led_src[i] & (pwm_cnt == '0);
          default:    led[i] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulx3s_board_io.sv
// tb_ulx3s_board_io
// Directed bench for ulx3s_board_io with short timing parameters
// (DB_CYCLES=4, LONG_CYCLES=20, PULSE_CYCLES=8, BLINK_DIV=6).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ulx3s_board_io;

  localparam int N_BTN = 7;
  localparam int N_LED = 8;

  logic               clk;
  logic               reset_n;
  logic [N_BTN-1:0]   btn_raw;
  logic [N_BTN-1:0]   btn_db;
  logic [N_BTN-1:0]   btn_rise;
  logic [N_BTN-1:0]   btn_fall;
  logic               short_press;
  logic               sys_reset;
  logic [N_LED-1:0]   led_src;
  logic [2*N_LED-1:0] led_mode;
  logic [N_LED-1:0]   led;

  int checks = 0;
  int errors = 0;

  ulx3s_board_io #(
    .N_BTN       (N_BTN),
    .N_LED       (N_LED),
    .DB_CYCLES   (4),
    .LONG_CYCLES (20),
    .PULSE_CYCLES(8),
    .RST_BTN     (1),
    .BLINK_DIV   (6)
  ) dut (
    .clk_48mhz  (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .short_press(short_press),
    .sys_reset  (sys_reset),
    .led_src    (led_src),
    .led_mode   (led_mode),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int highs;
    reset_n  = 1'b0;
    btn_raw  = '0;
    led_src  = '0;
    led_mode = '0;
    repeat (3) tick();
    checks++;
    if (sys_reset !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_sys_reset: got %b expected 1", sys_reset);
    end
    checks++;
    if (btn_db !== 7'h00 || btn_rise !== 7'h00 || btn_fall !== 7'h00) begin
      errors++; $display("[TB] FAIL rst_buttons: got db=%h rise=%h fall=%h expected 00", btn_db, btn_rise, btn_fall);
    end
    checks++;
    if (short_press !== 1'b0 || led !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_outputs: got short=%b led=%h expected 0/00", short_press, led);
    end
    // First cycle out of reset counts as pulse cycle 1
    reset_n = 1'b1;
    highs = (sys_reset === 1'b1) ? 1 : 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (sys_reset === 1'b1) highs++;
    end
    checks++;
    if (highs != 8) begin
      errors++; $display("[TB] FAIL por_pulse_len: got %0d high cycles expected 8", highs);
    end
    tick();
    checks++;
    if (sys_reset !== 1'b0) begin
      errors++; $display("[TB] FAIL por_pulse_end: got %b expected 0", sys_reset);
    end
    checks++;
    if (btn_db !== 7'h00 || short_press !== 1'b0 || led !== 8'h00) begin
      errors++; $display("[TB] FAIL por_others: got db=%h short=%b led=%h expected 00/0/00", btn_db, short_press, led);
    end
    repeat (2) tick();
  endtask

  task automatic test_debounce();
    int bad;
    // 3-cycle glitch must be rejected
    btn_raw[0] = 1'b1;
    repeat (3) tick();
    btn_raw[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (btn_db[0] !== 1'b0 || btn_rise[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL glitch_reject: got %0d bad cycles expected 0", bad);
    end
    // Clean press: accepted 6 cycles after the raw edge
    btn_raw[0] = 1'b1;
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (btn_db[0] !== 1'b0 || btn_rise[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL press_early: got %0d early cycles expected 0", bad);
    end
    tick();
    checks++;
    if (btn_db[0] !== 1'b1 || btn_rise[0] !== 1'b1 || btn_fall[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL press_accept: got db=%b rise=%b fall=%b expected 1/1/0", btn_db[0], btn_rise[0], btn_fall[0]);
    end
    tick();
    checks++;
    if (btn_db[0] !== 1'b1 || btn_rise[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL rise_one_cycle: got db=%b rise=%b expected 1/0", btn_db[0], btn_rise[0]);
    end
    // Clean release
    btn_raw[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (btn_db[0] !== 1'b1 || btn_fall[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL release_early: got db=%b fall=%b expected 1/0", btn_db[0], btn_fall[0]);
    end
    tick();
    checks++;
    if (btn_db[0] !== 1'b0 || btn_fall[0] !== 1'b1 || btn_rise[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL release_accept: got db=%b fall=%b rise=%b expected 0/1/0", btn_db[0], btn_fall[0], btn_rise[0]);
    end
    tick();
    checks++;
    if (btn_fall[0] !== 1'b0 || sys_reset !== 1'b0 || short_press !== 1'b0) begin
      errors++; $display("[TB] FAIL fall_one_cycle: got fall=%b sys=%b short=%b expected 0/0/0", btn_fall[0], sys_reset, short_press);
    end
  endtask

  task automatic test_long_press();
    int n;
    int highs;
    int bad;
    bit found;
    btn_raw[1] = 1'b1;
    found = 0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_rise[1] === 1'b1) begin found = 1; n = k; break; end
    end
    checks++;
    if (!found || n != 6) begin
      errors++; $display("[TB] FAIL long_rise: got found=%0d at cycle %0d expected cycle 6", found, n);
    end
    found = 0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (sys_reset === 1'b1) begin found = 1; n = k; break; end
    end
    checks++;
    if (!found || n != 20) begin
      errors++; $display("[TB] FAIL long_delay: got found=%0d after %0d cycles expected 20", found, n);
    end
    highs = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (sys_reset === 1'b1) highs++;
    end
    tick();
    checks++;
    if (highs != 8 || sys_reset !== 1'b0) begin
      errors++; $display("[TB] FAIL long_pulse: got %0d highs end=%b expected 8/0", highs, sys_reset);
    end
    // Keep holding: no retrigger
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (sys_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL long_no_retrigger: got %0d high cycles expected 0", bad);
    end
    btn_raw[1] = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sys_reset !== 1'b0 || short_press !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || btn_db[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL long_release: got %0d bad cycles db=%b expected 0/0", bad, btn_db[1]);
    end
  endtask

  task automatic test_short_press();
    int bad;
    int n;
    bit found;
    btn_raw[1] = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sys_reset !== 1'b0) bad++;
    end
    btn_raw[1] = 1'b0;
    found = 0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sys_reset !== 1'b0) bad++;
      if (btn_fall[1] === 1'b1) begin found = 1; n = k; break; end
    end
    checks++;
    if (!found || n != 6) begin
      errors++; $display("[TB] FAIL short_fall: got found=%0d at cycle %0d expected 6", found, n);
    end
    checks++;
    if (short_press !== 1'b0) begin
      errors++; $display("[TB] FAIL short_early: got %b expected 0", short_press);
    end
    tick();
    checks++;
    if (short_press !== 1'b1) begin
      errors++; $display("[TB] FAIL short_pulse: got %b expected 1", short_press);
    end
    tick();
    checks++;
    if (short_press !== 1'b0) begin
      errors++; $display("[TB] FAIL short_one_cycle: got %b expected 0", short_press);
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (sys_reset !== 1'b0 || short_press !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL short_no_reset: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_hold();
    int highs;
    int bad;
    bit found;
    btn_raw[1] = 1'b1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_rise[1] === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL midhold_rise: got no rise expected rise within 20 cycles");
    end
    // Hold counter reaches 15 here
    repeat (16) tick();
    checks++;
    if (sys_reset !== 1'b0) begin
      errors++; $display("[TB] FAIL midhold_before: got %b expected 0", sys_reset);
    end
    reset_n    = 1'b0;
    btn_raw[1] = 1'b0;
    repeat (2) tick();
    checks++;
    if (sys_reset !== 1'b1 || btn_db !== 7'h00) begin
      errors++; $display("[TB] FAIL midhold_in_reset: got sys=%b db=%h expected 1/00", sys_reset, btn_db);
    end
    reset_n = 1'b1;
    highs = (sys_reset === 1'b1) ? 1 : 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (sys_reset === 1'b1) highs++;
    end
    tick();
    checks++;
    if (highs != 8 || sys_reset !== 1'b0) begin
      errors++; $display("[TB] FAIL midhold_pulse: got %0d highs end=%b expected 8/0", highs, sys_reset);
    end
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (sys_reset !== 1'b0 || short_press !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL midhold_discard: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_leds();
    logic [N_LED-1:0] s [0:23];
    int t;
    int p;
    int bad;
    logic expv;
    led_src  = 8'hFF;
    led_mode = 16'hE4E4;
    tick();
    for (int k = 0; k < 24; k++) begin
      tick();
      s[k] = led;
    end
    bad = 0;
    for (int k = 0; k < 24; k++)
      if (s[k][0] !== 1'b0 || s[k][4] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL led_off: got %0d high cycles expected 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 24; k++)
      if (s[k][1] !== 1'b1 || s[k][5] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL led_direct: got %0d low cycles expected 0", bad);
    end
    // Blink: locate first toggle, then expect a toggle every 6 cycles
    t = -1;
    for (int k = 1; k <= 6; k++)
      if (t < 0 && s[k][2] !== s[k-1][2]) t = k;
    checks++;
    if (t < 0) begin
      errors++; $display("[TB] FAIL led_blink_toggle: got no toggle in 7 cycles expected one");
    end else begin
      bad = 0;
      for (int k = t; k < t + 18; k++) begin
        expv = s[t][2] ^ (((k - t) / 6) % 2 == 1);
        if (s[k][2] !== expv || s[k][6] !== expv) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("[TB] FAIL led_blink_period: got %0d wrong cycles expected 0", bad);
      end
    end
    // Dim: high exactly once every 8 cycles
    p = -1;
    for (int k = 0; k < 8; k++)
      if (p < 0 && s[k][3] === 1'b1) p = k;
    checks++;
    if (p < 0) begin
      errors++; $display("[TB] FAIL led_dim_on: got no high in 8 cycles expected one");
    end else begin
      bad = 0;
      for (int k = p; k < p + 16; k++) begin
        expv = ((k - p) % 8 == 0);
        if (s[k][3] !== expv || s[k][7] !== expv) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("[TB] FAIL led_dim_duty: got %0d wrong cycles expected 0", bad);
      end
    end
  endtask

  task automatic test_led_latency();
    led_mode = 16'h5555;
    led_src  = 8'hA5;
    tick();
    checks++;
    if (led !== 8'hA5) begin
      errors++; $display("[TB] FAIL led_latency_a: got %h expected a5", led);
    end
    led_src = 8'h3C;
    tick();
    checks++;
    if (led !== 8'h3C) begin
      errors++; $display("[TB] FAIL led_latency_b: got %h expected 3c", led);
    end
    led_mode = 16'hAAAA;
    led_src  = 8'h00;
    tick();
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("[TB] FAIL led_blink_src0: got %h expected 00", led);
    end
    led_mode = 16'h0000;
    led_src  = 8'hFF;
    tick();
    checks++;
    if (led !== 8'h00) begin
      errors++; $display("[TB] FAIL led_mode_off: got %h expected 00", led);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_long_press();
    test_short_press();
    test_reset_mid_hold();
    test_leds();
    test_led_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
